// File: rtl/ibex_fetch_requester.sv
// ibex_fetch_requester
//
// Request side of the instruction prefetch path. Issues word-aligned fetch
// requests on the instruction bus, tracks up to NUM_REQS outstanding
// transactions, discards responses made stale by a branch and pushes the
// surviving responses into the fetch FIFO. Issue is throttled by the FIFO's
// upper-entry busy vector so that every response granted has room to land.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i                fetching enabled
//   branch_i, addr_i     redirect fetch to addr_i (halfword aligned)
//   busy_o               request held or any response outstanding
//   fifo_busy_i          upper-entry occupancy of the fetch FIFO
//   fifo_clear_o         flush the FIFO (= branch_i)
//   fifo_valid_o         push the current response into the FIFO
//   fifo_addr_o          = addr_i, consumed by the FIFO on clear
//   fifo_rdata_o         = instr_rdata_i
//   fifo_err_o           = instr_err_i
//   instr_req_o/gnt_i    bus request handshake
//   instr_addr_o         word-aligned request address
//   instr_rvalid_i       response valid, with instr_rdata_i / instr_err_i

module ibex_fetch_requester #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,

    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,

    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    localparam int unsigned CNT_W = $clog2(2 * NUM_REQS + 1);

    logic [31:2]         fetch_addr_q, fetch_addr_d;
    logic [31:2]         stored_addr_q, stored_addr_d;
    logic                pending_q, pending_d;
    logic                pending_discard_q, pending_discard_d;
    logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;

    logic [CNT_W-1:0]    live_cnt;
    logic                may_issue;
    logic                slot_free;
    logic [31:2]         req_addr;
    logic                gnt_fire;
    logic                gnt_discard;
    logic [NUM_REQS-1:0] out_shift;
    logic [NUM_REQS-1:0] disc_shift;
    logic                filled;

    // Responses still destined for the FIFO plus entries already sitting in
    // its upper part; issuing only while this is below NUM_REQS guarantees
    // room for every live response.
    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            live_cnt = live_cnt + CNT_W'(outstanding_q[i] & ~discard_q[i])
                                + CNT_W'(fifo_busy_i[i]);
        end
    end

    // A branch flushes the FIFO in the same cycle, so it may always issue.
    assign may_issue = branch_i | (live_cnt < CNT_W'(NUM_REQS));
    // The top slot frees up in the same cycle its oldest response retires.
    assign slot_free = ~outstanding_q[NUM_REQS-1] | instr_rvalid_i;

    assign instr_req_o = pending_q | (req_i & may_issue & slot_free);

    // A held request keeps its address until granted, regardless of branches.
    always_comb begin
        if (pending_q) begin
            req_addr = stored_addr_q;
        end else if (branch_i) begin
            req_addr = addr_i[31:2];
        end else begin
            req_addr = fetch_addr_q;
        end
    end

    assign instr_addr_o = {req_addr, 2'b00};

    assign gnt_fire    = instr_req_o & instr_gnt_i;
    // Only a held request can be stale; a fresh request in a branch cycle
    // already targets the branch address.
    assign gnt_discard = pending_q & (pending_discard_q | branch_i);

    always_comb begin
        out_shift  = instr_rvalid_i ? (outstanding_q >> 1) : outstanding_q;
        disc_shift = instr_rvalid_i ? (discard_q >> 1)     : discard_q;
        if (branch_i) begin
            disc_shift = disc_shift | out_shift;
        end

        outstanding_d = out_shift;
        discard_d     = disc_shift;
        filled        = 1'b0;
        if (gnt_fire) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!out_shift[i] && !filled) begin
                    outstanding_d[i] = 1'b1;
                    discard_d[i]     = gnt_discard;
                    filled           = 1'b1;
                end
            end
        end

        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = addr_i[31:2];
        end
        if (gnt_fire && !gnt_discard) begin
            fetch_addr_d = req_addr + 30'd1;
        end

        pending_d         = pending_q;
        stored_addr_d     = stored_addr_q;
        pending_discard_d = pending_discard_q;
        if (instr_req_o && !instr_gnt_i) begin
            pending_d         = 1'b1;
            stored_addr_d     = req_addr;
            pending_discard_d = pending_q & (pending_discard_q | branch_i);
        end else if (gnt_fire) begin
            pending_d         = 1'b0;
            pending_discard_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q      <= '0;
            stored_addr_q     <= '0;
            pending_q         <= 1'b0;
            pending_discard_q <= 1'b0;
            outstanding_q     <= '0;
            discard_q         <= '0;
        end else begin
            fetch_addr_q      <= fetch_addr_d;
            stored_addr_q     <= stored_addr_d;
            pending_q         <= pending_d;
            pending_discard_q <= pending_discard_d;
            outstanding_q     <= outstanding_d;
            discard_q         <= discard_d;
        end
    end

    assign busy_o       = pending_q | (|outstanding_q);

    assign fifo_clear_o = branch_i;
    assign fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    a_rvalid_tracked : assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> (|outstanding_q));
    a_gnt_with_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_gnt_i |-> instr_req_o);
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_valid_o |-> !fifo_busy_i[NUM_REQS-1]);

endmodule
